// File: rtl/param_arb_mux_pkg.sv
// Shared types and helpers for the arbitrated output multiplexer.
package param_mux_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Wraps M-1 back to 0 so non-power-of-two channel counts never reach M.
    function automatic int unsigned ptr_inc(input int unsigned k, input int unsigned m);
        if (k + 32'd1 >= m) begin
            return 32'd0;
        end
        return k + 32'd1;
    endfunction

endpackage

// File: rtl/param_arb_mux_arb.sv
// Combinational arbiter: round-robin from ptr, or fixed priority from index 0.
module rr_arbiter
    import param_mux_pkg::*;
#(
    parameter  int unsigned M = 4,
    localparam int unsigned S = $clog2(M)
) (
    input  logic [M-1:0] req,
    input  logic [S-1:0] ptr,
    input  arb_mode_e    mode,
    output logic [M-1:0] grant,
    output logic [S-1:0] idx,
    output logic         any_grant
);

    always_comb begin
        int unsigned base;
        int unsigned c;
        logic [S-1:0] ci;
        base      = '0;
        c         = '0;
        ci        = '0;
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        if (mode == ARB_RR) begin
            base = 32'(ptr);
        end
        for (int unsigned i = 0; i < M; i++) begin
            c = base + i;
            if (c >= M) begin
                c = c - M;
            end
            ci = S'(c);
            if (!any_grant && req[ci]) begin
                grant[ci] = 1'b1;
                idx       = ci;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_arb_mux.sv
// Registered M-channel mux with valid/ready handshakes and built-in arbitration.
module param_arb_mux
    import param_mux_pkg::*;
#(
    parameter  int unsigned N = 3,
    parameter  int unsigned M = 4,
    localparam int unsigned S = $clog2(M),
    localparam int unsigned W = 2**N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mode,
    input  logic [M-1:0]   x_valid,
    input  logic [M*W-1:0] x_data,
    output logic [M-1:0]   x_ready,
    output logic           y_valid,
    output logic [W-1:0]   y,
    output logic [S-1:0]   y_sel,
    input  logic           y_ready
);

    arb_mode_e    mode_e;
    logic [S-1:0] ptr;
    logic [M-1:0] grant;
    logic [S-1:0] idx;
    logic         any_grant;
    logic         stage_open;
    logic         transfer;
    logic [W-1:0] word;

    assign mode_e = arb_mode_e'(mode);

    rr_arbiter #(
        .M(M)
    ) u_arb (
        .req      (x_valid),
        .ptr      (ptr),
        .mode     (mode_e),
        .grant    (grant),
        .idx      (idx),
        .any_grant(any_grant)
    );

    assign stage_open = !y_valid || y_ready;
    // Reset is async, so gate explicitly: the cleared register alone would read as open.
    assign transfer   = any_grant && stage_open && !reset;
    assign x_ready    = transfer ? grant : '0;
    assign word       = x_data[32'(idx) * W +: W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_valid <= 1'b0;
            y       <= '0;
            y_sel   <= '0;
            ptr     <= '0;
        end else if (transfer) begin
            y_valid <= 1'b1;
            y       <= word;
            y_sel   <= idx;
            if (mode_e == ARB_RR) begin
                ptr <= S'(ptr_inc(32'(idx), M));
            end
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_arb_mux.sv
// Scoreboard bench for param_arb_mux: directed scenarios followed by random traffic.
module tb_param_arb_mux;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [3:0]  x_valid;
    logic [31:0] x_data;
    logic [3:0]  x_ready;
    logic        y_valid;
    logic [7:0]  y;
    logic [1:0]  y_sel;
    logic        y_ready;

    logic        mode3;
    logic [2:0]  x_valid3;
    logic [23:0] x_data3;
    logic [2:0]  x_ready3;
    logic        y_valid3;
    logic [7:0]  y3;
    logic [1:0]  y_sel3;
    logic        y_ready3;

    param_arb_mux #(.N(3), .M(4)) dut (
        .clk(clk), .reset(reset), .mode(mode), .x_valid(x_valid), .x_data(x_data),
        .x_ready(x_ready), .y_valid(y_valid), .y(y), .y_sel(y_sel), .y_ready(y_ready)
    );

    param_arb_mux #(.N(3), .M(3)) dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .x_valid(x_valid3), .x_data(x_data3),
        .x_ready(x_ready3), .y_valid(y_valid3), .y(y3), .y_sel(y_sel3), .y_ready(y_ready3)
    );

    typedef struct {
        logic [7:0] d;
        int         sel;
    } item_t;

    item_t      exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic       chk_en;
    logic       mv;
    int         mptr;
    logic [3:0] acc_mask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] v, input int start);
        for (int i = 0; i < 4; i++) begin
            if (v[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    // Reference model: decides each cycle's transfer from the rules and queues the word.
    always @(negedge clk) begin
        int         start;
        int         g;
        logic [3:0] er;
        item_t      it;
        if (!reset && chk_en) begin
            check("y_valid_model", 32'(y_valid), 32'(mv));
            start = mode ? 0 : mptr;
            g     = pick(x_valid, start);
            er    = '0;
            if ((!mv || y_ready) && g >= 0) er[g] = 1'b1;
            check("x_ready_model", 32'(x_ready), 32'(er));
            acc_mask = x_valid & x_ready;
            if (er != 4'b0) begin
                it.d   = x_data[g*8 +: 8];
                it.sel = g;
                exp_q.push_back(it);
                mv = 1'b1;
                if (!mode) mptr = (g + 1) % 4;
            end else if (y_ready) begin
                mv = 1'b0;
            end
        end
    end

    // Monitor: a word is consumed at the next edge whenever y_valid && y_ready.
    always @(negedge clk) begin
        item_t it;
        if (!reset && chk_en && y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_nonempty", 32'(exp_q.size()), 32'd1);
            end else begin
                it = exp_q.pop_front();
                check("sb_y", 32'(y), 32'(it.d));
                check("sb_y_sel", 32'(y_sel), 32'(it.sel));
            end
        end
    end

    initial begin
        reset = 1'b1; mode = 1'b0; x_valid = '0; x_data = '0; y_ready = 1'b0;
        mode3 = 1'b0; x_valid3 = '0; x_data3 = '0; y_ready3 = 1'b1;
        chk_en = 1'b0; mv = 1'b0; mptr = 0; acc_mask = '0;
        repeat (2) step();
        check("rst_y_valid", 32'(y_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_y_sel", 32'(y_sel), 32'd0);
        check("rst_x_ready", 32'(x_ready), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Round-robin fairness with every channel requesting
        mode = 1'b0; x_valid = 4'hF; x_data = 32'h13121110; y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_sel", 32'(y_sel), 32'(i % 4));
            check("rr_y", 32'(y), 32'(8'h10 + i % 4));
            check("rr_valid", 32'(y_valid), 32'd1);
        end

        // Fixed priority: channel 1 beats channel 3 until it stops requesting
        mode = 1'b1; x_valid = 4'b1010; x_data = 32'hB3B2B1B0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fix_sel", 32'(y_sel), 32'd1);
        end
        x_valid = 4'b1000;
        step();
        check("fix_sel3", 32'(y_sel), 32'd3);

        // Back-pressure
        mode = 1'b0; x_valid = 4'b0001; x_data = 32'h0000553C;
        step();
        check("bp_load", 32'(y), 32'h3C);
        y_ready = 1'b0; x_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_y", 32'(y), 32'h3C);
            check("bp_xready", 32'(x_ready), 32'd0);
        end
        y_ready = 1'b1;
        #1 check("bp_release_xready", 32'(x_ready), 32'b0010);
        step();
        check("bp_next_y", 32'(y), 32'h55);
        check("bp_next_valid", 32'(y_valid), 32'd1);

        // Pointer skip and wrap on M=4, then wrap on M=3
        x_valid = 4'b0100;
        step();
        x_valid = 4'b0001;
        #1 check("wrap_grant0", 32'(x_ready), 32'b0001);
        step();
        x_valid = 4'b1111;
        #1 check("wrap_ptr1", 32'(x_ready), 32'b0010);
        x_valid3 = 3'b100; x_data3 = 24'h222120;
        #1 check("m3_grant2", 32'(x_ready3), 32'b100);
        step();
        check("m3_sel2", 32'(y_sel3), 32'd2);
        x_valid3 = 3'b111;
        #1 check("m3_wrap0", 32'(x_ready3), 32'b001);
        step();
        check("m3_sel0", 32'(y_sel3), 32'd0);
        check("m3_y", 32'(y3), 32'h20);
        #1 check("m3_next1", 32'(x_ready3), 32'b010);
        x_valid3 = '0;

        // Mode switch: ptr survives a fixed-priority period
        x_valid = 4'b0010; mode = 1'b0;
        step();
        mode = 1'b1; x_valid = 4'b0001;
        repeat (3) step();
        mode = 1'b0; x_valid = 4'b1111;
        #1 check("ms_grant2", 32'(x_ready), 32'b0100);
        step();
        check("ms_sel2", 32'(y_sel), 32'd2);

        // Reset mid-stream with a held word
        x_valid = 4'b0001; x_data = 32'h000000A5; y_ready = 1'b1;
        step();
        x_valid = 4'b0000; y_ready = 1'b0;
        #1 check("pre_rst_y", 32'(y), 32'hA5);
        check("pre_rst_valid", 32'(y_valid), 32'd1);
        #1;
        reset = 1'b1; chk_en = 1'b0;
        exp_q.delete(); mv = 1'b0; mptr = 0; acc_mask = '0;
        y_ready = 1'b1; x_valid = 4'b1111;
        #1;
        check("arst_y_valid", 32'(y_valid), 32'd0);
        check("arst_y", 32'(y), 32'd0);
        check("arst_y_sel", 32'(y_sel), 32'd0);
        check("arst_x_ready", 32'(x_ready), 32'd0);
        step();
        check("arst_x_ready_edge", 32'(x_ready), 32'd0);
        reset = 1'b0;
        #1 check("post_rst_grant0", 32'(x_ready), 32'b0001);
        chk_en = 1'b1;

        // Random traffic respecting the producer hold rule
        for (int n = 0; n < 2000; n++) begin
            step();
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            y_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                if (!x_valid[k] || acc_mask[k]) begin
                    x_valid[k] = 1'($urandom_range(0, 1));
                    x_data[k*8 +: 8] = 8'($urandom);
                end
            end
        end

        x_valid = '0; y_ready = 1'b1;
        repeat (4) step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
